muldiv_seq_ctrl: RTL and testbench

- Multi-cycle controller and datapath for the MUL/DIV instructions; replaces the single-cycle combinational multiply in the ALU path.
- Multiply: sequential radix-4 Booth, one bit pair retired per clock.
- Divide: restoring division, signed correction at the end.
- Results land in the HI/LO register inputs; the control unit sequences it with a start/done handshake and stalls on busy.

---
 rtl/muldiv_pkg.sv | 48 ++++
 rtl/muldiv_seq_ctrl_booth_recode.sv | 27 ++
 rtl/muldiv_seq_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_muldiv_seq_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types for the sequential MUL/DIV unit: op codes, FSM states,
// iteration-count derivation and the radix-4 Booth group decode.
package muldiv_pkg;

    localparam logic [1:0] OP_MUL = 2'b00;
    localparam logic [1:0] OP_DIV = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Magnitude of the Booth multiple; the sign travels separately in booth_sel_t.
    typedef enum logic [1:0] {
        BM_ZERO = 2'd0,
        BM_ONE  = 2'd1,
        BM_TWO  = 2'd2
    } booth_mag_t;

    typedef struct packed {
        logic       neg;
        booth_mag_t mag;
    } booth_sel_t;

    function automatic int mul_iters(input int width);
        return width / 2;
    endfunction

    function automatic int div_iters(input int width);
        return width;
    endfunction

    function automatic booth_sel_t booth_decode(input logic [2:0] grp);
        booth_sel_t sel;
        case (grp)
            3'b001, 3'b010: sel = '{neg: 1'b0, mag: BM_ONE};
            3'b011:         sel = '{neg: 1'b0, mag: BM_TWO};
            3'b100:         sel = '{neg: 1'b1, mag: BM_TWO};
            3'b101, 3'b110: sel = '{neg: 1'b1, mag: BM_ONE};
            default:        sel = '{neg: 1'b0, mag: BM_ZERO};
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/muldiv_seq_ctrl_booth_recode.sv
// Radix-4 Booth recoder: turns one 3-bit multiplier group into the A/2A
// multiple plus a negate flag for the accumulator.
module booth_recode
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]         grp,
    input  logic [WIDTH-1:0]   mcand,
    output logic signed [WIDTH:0] multiple,
    output logic               negate
);

    booth_sel_t sel;

    // Negation is left to the 2W-wide accumulator: -2*(-2^(W-1)) needs W+2 bits.
    always_comb begin
        sel    = booth_decode(grp);
        negate = sel.neg;
        case (sel.mag)
            BM_ONE:  multiple = {mcand[WIDTH-1], mcand};
            BM_TWO:  multiple = {mcand, 1'b0};
            default: multiple = '0;
        endcase
    end

endmodule

// File: rtl/muldiv_seq_ctrl.sv
// Multi-cycle MUL (radix-4 Booth) / DIV (restoring) unit with start/done handshake.
// Build option: MULDIV_EARLY_TERM_EN ends MUL once the remaining multiplier bits are all sign.
//
//   state | meaning
//   IDLE  | waiting for start; operands latched on accept
//   MUL   | one Booth group per cycle into the 2W accumulator
//   DIV   | one restoring step per cycle on |A| / |B|
//   FIX   | apply quotient / remainder signs
//   DONE  | done pulse; hi/lo/div_by_zero already registered
module muldiv_seq_ctrl
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int MUL_ITERS = mul_iters(WIDTH);
    localparam int DIV_ITERS = div_iters(WIDTH);
    localparam int CNT_W     = $clog2(DIV_ITERS);

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   areg, breg;
    logic [2*WIDTH-1:0] acc;
    logic               a_neg, b_neg;

    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     b_ext;
    logic [CNT_W:0]     idx;
    logic [2:0]         grp;
    logic signed [WIDTH:0] multiple;
    logic               negate;
    logic [2*WIDTH-1:0] pp, mul_acc_nx;
    logic               mul_rest_eq, mul_last, div_last;

    logic [WIDTH:0]     rem_sh;
    logic               div_ge;
    logic [WIDTH-1:0]   rem_nx;
    logic [2*WIDTH-1:0] div_acc_nx;
    logic [WIDTH-1:0]   q_fix, r_fix;

    logic [WIDTH-1:0]   res_hi, res_lo;
    logic               res_dbz;

    assign a_mag = A[WIDTH-1] ? (~A + 1'b1) : A;
    assign b_mag = B[WIDTH-1] ? (~B + 1'b1) : B;

    // Multiplier datapath
    assign b_ext = {breg, 1'b0};
    assign idx   = {cnt, 1'b0};
    assign grp   = b_ext[idx +: 3];

    booth_recode #(.WIDTH(WIDTH)) u_booth (
        .grp      (grp),
        .mcand    (areg),
        .multiple (multiple),
        .negate   (negate)
    );

    assign pp         = {{(WIDTH-1){multiple[WIDTH]}}, multiple} << idx;
    assign mul_acc_nx = negate ? (acc - pp) : (acc + pp);

`ifdef MULDIV_EARLY_TERM_EN
    logic [WIDTH-1:0] rest;
    assign rest        = $signed(breg) >>> {cnt, 1'b1};
    assign mul_rest_eq = (rest == '0) || (rest == '1);
`else
    assign mul_rest_eq = 1'b0;
`endif

    assign mul_last = (cnt == CNT_W'(MUL_ITERS - 1)) || mul_rest_eq;
    assign div_last = (cnt == CNT_W'(DIV_ITERS - 1));

    // Divider datapath: acc holds {remainder, quotient}
    assign rem_sh     = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_ge     = rem_sh >= {1'b0, breg};
    assign rem_nx     = div_ge ? WIDTH'(rem_sh - {1'b0, breg}) : rem_sh[WIDTH-1:0];
    assign div_acc_nx = {rem_nx, acc[WIDTH-2:0], div_ge};

    assign q_fix = (a_neg ^ b_neg) ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
    assign r_fix = a_neg ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (start && op == OP_MUL)
                    state_nx = ST_MUL;
                else if (start && op == OP_DIV)
                    state_nx = (B == '0) ? ST_DONE : ST_DIV;
            end
            ST_MUL:  if (mul_last) state_nx = ST_DONE;
            ST_DIV:  if (div_last) state_nx = ST_FIX;
            ST_FIX:  state_nx = ST_DONE;
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Result selected by whichever state is about to enter DONE
    always_comb begin
        res_hi  = mul_acc_nx[2*WIDTH-1:WIDTH];
        res_lo  = mul_acc_nx[WIDTH-1:0];
        res_dbz = 1'b0;
        case (state)
            ST_IDLE: begin
                res_hi  = A;
                res_lo  = '1;
                res_dbz = 1'b1;
            end
            ST_FIX: begin
                res_hi = r_fix;
                res_lo = q_fix;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            areg        <= '0;
            breg        <= '0;
            acc         <= '0;
            a_neg       <= 1'b0;
            b_neg       <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                ST_IDLE: begin
                    if (state_nx != ST_IDLE) begin
                        cnt   <= '0;
                        areg  <= A;
                        a_neg <= A[WIDTH-1];
                        b_neg <= B[WIDTH-1];
                        if (op == OP_MUL) begin
                            breg <= B;
                            acc  <= '0;
                        end else begin
                            breg <= b_mag;
                            acc  <= {{WIDTH{1'b0}}, a_mag};
                        end
                    end
                end
                ST_MUL: begin
                    acc <= mul_acc_nx;
                    cnt <= cnt + CNT_W'(1);
                end
                ST_DIV: begin
                    acc <= div_acc_nx;
                    cnt <= cnt + CNT_W'(1);
                end
                default: ;
            endcase
            if (state != ST_DONE && state_nx == ST_DONE) begin
                hi          <= res_hi;
                lo          <= res_lo;
                div_by_zero <= res_dbz;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
// Self-checking bench for muldiv_seq_ctrl: directed corner cases plus random
// MUL/DIV traffic compared against a plain-arithmetic reference model.
module tb_muldiv_seq_ctrl;

    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op    = 2'b00;
    logic [31:0] a_in  = '0;
    logic [31:0] b_in  = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int total = 0;
    int bad   = 0;
    logic [31:0] last_hi, last_lo;

    always #5 clock = ~clock;

    muldiv_seq_ctrl #(.WIDTH(32)) dut (
        .clock       (clock),
        .clear       (clear),
        .start       (start),
        .op          (op),
        .A           (a_in),
        .B           (b_in),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Returns {div_by_zero, hi, lo}
    function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, p, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (o == 2'b00) begin
            p = sa * sb;
            return {1'b0, p[63:0]};
        end
        if (b == 32'd0)
            return {1'b1, a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {1'b0, r[31:0], q[31:0]};
    endfunction

    // Cycles from the accepting edge to the done cycle, inclusive of the accept cycle.
    function automatic int exp_latency(input logic [1:0] o, input logic [31:0] b);
        int iters;
        longint sb, lim;
        if (o == 2'b01)
            return (b == 32'd0) ? 1 : 34;
        iters = 16;
`ifdef MULDIV_EARLY_TERM_EN
        // Multiplier that fits in 2k signed bits needs only k Booth groups.
        sb = longint'($signed(b));
        for (int k = 1; k <= 16; k++) begin
            lim = longint'(1) <<< (2 * k - 1);
            if (sb >= -lim && sb < lim) begin
                iters = k;
                break;
            end
        end
`else
        sb  = 0;
        lim = 0;
`endif
        return iters + 1;
    endfunction

    function automatic logic [31:0] pick_val();
        logic [31:0] v;
        case ($urandom_range(0, 3))
            0: v = 32'($signed($urandom_range(0, 127)) - 64);
            1: case ($urandom_range(0, 4))
                   0: v = 32'h8000_0000;
                   1: v = 32'h7FFF_FFFF;
                   2: v = 32'hFFFF_FFFF;
                   3: v = 32'h0000_0001;
                   default: v = 32'h0000_0000;
               endcase
            default: v = $urandom;
        endcase
        return v;
    endfunction

    task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input int poke_at);
        logic [64:0] expv;
        int exp_lat, lat, busy_lo;
        bit seen;
        expv    = model(o, a, b);
        exp_lat = exp_latency(o, b);
        @(negedge clock);
        start = 1'b1; op = o; a_in = a; b_in = b;
        @(posedge clock);
        #1;
        start = 1'b0; a_in = $urandom; b_in = $urandom;
        lat = 1; busy_lo = 0; seen = 1'b0;
        while (lat <= 60) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (!busy) busy_lo++;
            if (lat == poke_at) begin
                start = 1'b1; op = 2'b00; a_in = $urandom; b_in = $urandom;
            end
            @(posedge clock);
            #1;
            start = 1'b0;
            lat++;
        end
        check({tag, "_seen"}, 64'(seen), 64'd1);
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_hi"}, 64'(hi), 64'(expv[63:32]));
        check({tag, "_lo"}, 64'(lo), 64'(expv[31:0]));
        check({tag, "_dbz"}, 64'(div_by_zero), 64'(expv[64]));
        check({tag, "_busy"}, 64'(busy_lo), 64'd0);
        last_hi = expv[63:32];
        last_lo = expv[31:0];
        @(posedge clock);
        #1;
        check({tag, "_pulse"}, 64'(done), 64'd0);
        check({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    task automatic count_dones(input string tag, input int cycles);
        int n;
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clock);
            #1;
            if (done) n++;
        end
        check(tag, 64'(n), 64'd0);
    endtask

    initial begin
        #12;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_dbz", 64'(div_by_zero), 64'd0);
        @(negedge clock);
        clear = 1'b0;

        do_op("mul_7_m3", 2'b00, 32'd7, 32'hFFFF_FFFD, -1);
        do_op("mul_min_min", 2'b00, 32'h8000_0000, 32'h8000_0000, -1);
        do_op("mul_m1_m1", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
        do_op("mul_100_3", 2'b00, 32'd100, 32'd3, -1);
        do_op("div_m7_2", 2'b01, 32'hFFFF_FFF9, 32'd2, -1);
        do_op("div_min_m1", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, -1);
        do_op("div_zero", 2'b01, 32'h0000_1234, 32'd0, -1);

        do_op("mul_poke", 2'b00, 32'h0001_2345, 32'hFFFE_0001, 5);
        count_dones("poke_no_second_done", 30);

        // Reserved op: no activity, outputs keep the previous result
        @(negedge clock);
        start = 1'b1; op = 2'b10; a_in = 32'd5; b_in = 32'd6;
        @(posedge clock);
        #1;
        start = 1'b0;
        check("rsv_busy", 64'(busy), 64'd0);
        count_dones("rsv_no_done", 20);
        check("rsv_hold_hi", 64'(hi), 64'(last_hi));
        check("rsv_hold_lo", 64'(lo), 64'(last_lo));

        // Clear in the middle of a divide
        @(negedge clock);
        start = 1'b1; op = 2'b01; a_in = 32'd1000; b_in = 32'd7;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (7) @(posedge clock);
        #3;
        clear = 1'b1;
        #1;
        check("clr_busy", 64'(busy), 64'd0);
        check("clr_done", 64'(done), 64'd0);
        check("clr_hi", 64'(hi), 64'd0);
        check("clr_lo", 64'(lo), 64'd0);
        check("clr_dbz", 64'(div_by_zero), 64'd0);
        @(negedge clock);
        clear = 1'b0;
        count_dones("clr_no_done", 40);
        do_op("mul_after_clr", 2'b00, 32'hFFFF_FF9C, 32'd12345, -1);

        for (int i = 0; i < 40; i++) begin
            logic [1:0]  o;
            logic [31:0] a, b;
            o = 2'($urandom_range(0, 1));
            a = pick_val();
            b = pick_val();
            do_op($sformatf("rnd%0d", i), o, a, b, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
